// File: rtl/vlc_tx_pkg.sv
// Shared definitions for the VLC TX slot scheduler: state and owner encodings,
// counter width and default timing constants.
package vlc_tx_pkg;

   localparam int unsigned CNT_W = 32;

   localparam logic [CNT_W-1:0] DEF_GUARD_CYCLES    = 32'd1000;
   localparam logic [CNT_W-1:0] DEF_MAX_HOLD_CYCLES = 32'd4000000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BEACON = 2'd1,
      S_DATA   = 2'd2,
      S_GUARD  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_BEACON = 1'b0,
      OWN_DATA   = 1'b1
   } owner_e;

endpackage

// File: rtl/sched_cycle_timer.sv
// 32-bit up-counter with synchronous clear, count enable and a terminal flag
// that is high while enabled and the count equals term.
module sched_cycle_timer
   import vlc_tx_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             at_term_c
);

   logic [CNT_W-1:0] cnt_q;

   // Count register: clear wins over enable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign at_term_c = en & (cnt_q == term);

endmodule

// File: rtl/vlc_tx_slot_scheduler.sv
// Arbitrates the single VLC LED between beacon pulses and UART data frames,
// with two-way round robin on ties, a guard gap between owners and a per-source
// lockout against stuck requests.
// Optional forced release after MAX_HOLD_CYCLES: define VLC_SCHED_TIMEOUT_EN.
module vlc_tx_slot_scheduler
   import vlc_tx_pkg::*;
#(
   parameter logic [CNT_W-1:0] GUARD_CYCLES    = DEF_GUARD_CYCLES,
   parameter logic [CNT_W-1:0] MAX_HOLD_CYCLES = DEF_MAX_HOLD_CYCLES,
   parameter logic             IDLE_LEVEL      = 1'b0
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_beacon_req,
   output logic o_beacon_gnt,
   input  logic i_beacon_pulse,
   input  logic i_data_req,
   output logic o_data_gnt,
   input  logic i_data_bit,
   input  logic i_data_done,
   output logic o_led,
   output logic o_busy,
   output logic o_timeout
);

   // Both counts must be at least one cycle.
   if (GUARD_CYCLES == '0 || MAX_HOLD_CYCLES == '0) begin : g_cfg_check
      $error("vlc_tx_slot_scheduler: GUARD_CYCLES and MAX_HOLD_CYCLES must be >= 1");
   end

   state_e state_q, state_d;
   owner_e last_q, last_d;
   logic   b_lock_q, b_lock_d;
   logic   d_lock_q, d_lock_d;
   logic   b_gnt_d, d_gnt_d, led_d, busy_d, timeout_d;
   logic   b_elig_c, d_elig_c;
   logic   guard_term_c;

   assign b_elig_c = i_beacon_req & ~b_lock_q;
   assign d_elig_c = i_data_req & ~d_lock_q;

   // Guard gap timer, cleared whenever the FSM is outside S_GUARD.
   sched_cycle_timer u_guard_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .clr       (state_q != S_GUARD),
      .en        (state_q == S_GUARD),
      .term      (GUARD_CYCLES - CNT_W'(1)),
      .at_term_c (guard_term_c)
   );

`ifdef VLC_SCHED_TIMEOUT_EN
   logic hold_term_c;

   // Ownership timer, cleared whenever no source owns the LED.
   sched_cycle_timer u_hold_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .clr       (state_q != S_BEACON && state_q != S_DATA),
      .en        (state_q == S_BEACON || state_q == S_DATA),
      .term      (MAX_HOLD_CYCLES - CNT_W'(1)),
      .at_term_c (hold_term_c)
   );
`endif

   // State, arbitration history, lockouts and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         last_q       <= OWN_DATA;
         b_lock_q     <= 1'b0;
         d_lock_q     <= 1'b0;
         o_beacon_gnt <= 1'b0;
         o_data_gnt   <= 1'b0;
         o_led        <= IDLE_LEVEL;
         o_busy       <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         b_lock_q     <= b_lock_d;
         d_lock_q     <= d_lock_d;
         o_beacon_gnt <= b_gnt_d;
         o_data_gnt   <= d_gnt_d;
         o_led        <= led_d;
         o_busy       <= busy_d;
         o_timeout    <= timeout_d;
      end
   end

   // Next state, lockouts and next output values.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (b_elig_c && d_elig_c) begin
               state_d = (last_q == OWN_DATA) ? S_BEACON : S_DATA;
            end else if (b_elig_c) begin
               state_d = S_BEACON;
            end else if (d_elig_c) begin
               state_d = S_DATA;
            end
         end
         S_BEACON: begin
            if (!i_beacon_req) begin
               state_d = S_GUARD;
`ifdef VLC_SCHED_TIMEOUT_EN
            end else if (hold_term_c) begin
               state_d   = S_GUARD;
               timeout_d = 1'b1;
`endif
            end
         end
         S_DATA: begin
            if (!i_data_req || i_data_done) begin
               state_d = S_GUARD;
`ifdef VLC_SCHED_TIMEOUT_EN
            end else if (hold_term_c) begin
               state_d   = S_GUARD;
               timeout_d = 1'b1;
`endif
            end
         end
         S_GUARD: begin
            if (guard_term_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_IDLE && state_d == S_BEACON) begin
         last_d = OWN_BEACON;
      end else if (state_q == S_IDLE && state_d == S_DATA) begin
         last_d = OWN_DATA;
      end

      // A released owner stays locked out until its request is seen low.
      if (!i_beacon_req) begin
         b_lock_d = 1'b0;
      end else if (state_q == S_BEACON && state_d == S_GUARD) begin
         b_lock_d = 1'b1;
      end else begin
         b_lock_d = b_lock_q;
      end

      if (!i_data_req) begin
         d_lock_d = 1'b0;
      end else if (state_q == S_DATA && state_d == S_GUARD) begin
         d_lock_d = 1'b1;
      end else begin
         d_lock_d = d_lock_q;
      end

      b_gnt_d = (state_d == S_BEACON);
      d_gnt_d = (state_d == S_DATA);
      busy_d  = (state_d != S_IDLE);
      case (state_d)
         S_BEACON: led_d = i_beacon_pulse;
         S_DATA:   led_d = i_data_bit;
         default:  led_d = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_vlc_tx_slot_scheduler.sv
// Directed bench for vlc_tx_slot_scheduler: a vector table for beacon/data
// ownership, guard gap and lockout, then sequences for async reset, round
// robin ties and (with VLC_SCHED_TIMEOUT_EN) forced release.
module tb_vlc_tx_slot_scheduler;

   localparam logic [31:0] GUARD    = 32'd8;
   localparam logic [31:0] MAX_HOLD = 32'd100;
   localparam int          N_VEC    = 27;

   typedef struct packed {
      logic b_req;
      logic pulse;
      logic d_req;
      logic bitv;
      logic done;
      logic bgnt;
      logic dgnt;
      logic led;
      logic busy;
   } vec_t;

   logic clk;
   logic rst_n;
   logic beacon_req, beacon_pulse, data_req, data_bit, data_done;
   logic beacon_gnt, data_gnt, led, busy, timeout;

   int checks = 0;
   int errors = 0;
   vec_t tbl [N_VEC];

   vlc_tx_slot_scheduler #(
      .GUARD_CYCLES    (GUARD),
      .MAX_HOLD_CYCLES (MAX_HOLD),
      .IDLE_LEVEL      (1'b0)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_beacon_req   (beacon_req),
      .o_beacon_gnt   (beacon_gnt),
      .i_beacon_pulse (beacon_pulse),
      .i_data_req     (data_req),
      .o_data_gnt     (data_gnt),
      .i_data_bit     (data_bit),
      .i_data_done    (data_done),
      .o_led          (led),
      .o_busy         (busy),
      .o_timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      beacon_req   = v.b_req;
      beacon_pulse = v.pulse;
      data_req     = v.d_req;
      data_bit     = v.bitv;
      data_done    = v.done;
   endtask

   task automatic do_reset();
      beacon_req   = 1'b0;
      beacon_pulse = 1'b0;
      data_req     = 1'b0;
      data_bit     = 1'b0;
      data_done    = 1'b0;
      rst_n        = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for any grant; returns the number of edges waited.
   task automatic wait_any_gnt(output int n);
      n = 0;
      while (!beacon_gnt && !data_gnt && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;

      // Fields: b_req pulse d_req bit done | bgnt dgnt led busy
      tbl[0]  = 9'b11000_1011;                        // beacon granted, led = pulse
      tbl[1]  = 9'b10001_1001;                        // done ignored outside data
      tbl[2]  = 9'b11000_1011;
      tbl[3]  = 9'b01000_0001;                        // release -> guard, led idle
      for (int i = 4; i <= 10; i++) tbl[i] = 9'b00110_0001;  // data req during guard
      tbl[11] = 9'b00110_0000;                        // guard over -> idle
      tbl[12] = 9'b00110_0111;                        // data granted 9 after beacon fall
      tbl[13] = 9'b00100_0101;
      tbl[14] = 9'b00111_0001;                        // done with req high -> release
      for (int i = 15; i <= 21; i++) tbl[i] = 9'b00110_0001;
      tbl[22] = 9'b00110_0000;                        // idle, data locked out
      tbl[23] = 9'b00110_0000;
      tbl[24] = 9'b00010_0000;                        // req low clears lockout
      tbl[25] = 9'b00110_0111;                        // regranted
      tbl[26] = 9'b00100_0101;

      // Reset values
      rst_n = 1'b0;
      drive(9'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_bgnt", beacon_gnt, 1'b0);
      chk("reset_dgnt", data_gnt, 1'b0);
      chk("reset_led", led, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_timeout", timeout, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < N_VEC; i++) begin
         drive(tbl[i]);
         tick();
         chk($sformatf("vec%0d_bgnt", i), beacon_gnt, tbl[i].bgnt);
         chk($sformatf("vec%0d_dgnt", i), data_gnt, tbl[i].dgnt);
         chk($sformatf("vec%0d_led", i), led, tbl[i].led);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      end

      // Asynchronous reset in the middle of a data frame
      data_bit = 1'b1;
      tick();
      chk("midrst_pre_led", led, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_dgnt", data_gnt, 1'b0);
      chk("midrst_led", led, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("midrst_idle_busy", busy, 1'b0);
      tick();
      chk("midrst_regrant", data_gnt, 1'b1);

      // Round robin ties
      do_reset();
      beacon_req = 1'b1;
      data_req   = 1'b1;
      tick();
      chk("tie1_bgnt", beacon_gnt, 1'b1);
      chk("tie1_dgnt", data_gnt, 1'b0);
      tick();
      beacon_req = 1'b0;
      tick();
      chk("tie1_release", beacon_gnt, 1'b0);
      n = 0;
      while (!data_gnt && n < 40) begin
         tick();
         n++;
      end
      chk_int("guard_gap", n, 9);
      data_req = 1'b0;
      tick();
      chk("data_release", data_gnt, 1'b0);
      beacon_req = 1'b1;
      data_req   = 1'b1;
      wait_any_gnt(n);
      chk("tie2_bgnt", beacon_gnt, 1'b1);
      chk("tie2_dgnt", data_gnt, 1'b0);
      beacon_req = 1'b0;
      data_req   = 1'b0;
      tick();
      tick();
      beacon_req = 1'b1;
      data_req   = 1'b1;
      wait_any_gnt(n);
      chk("tie3_bgnt", beacon_gnt, 1'b0);
      chk("tie3_dgnt", data_gnt, 1'b1);

      // Stuck data request
      do_reset();
      data_req = 1'b1;
      data_bit = 1'b1;
      tick();
      chk("stuck_gnt", data_gnt, 1'b1);
`ifdef VLC_SCHED_TIMEOUT_EN
      n = 0;
      while (data_gnt && n < 300) begin
         tick();
         n++;
      end
      chk_int("hold_len", n, 100);
      chk("to_pulse", timeout, 1'b1);
      chk("to_led", led, 1'b0);
      tick();
      chk("to_pulse_end", timeout, 1'b0);
      repeat (20) tick();
      chk("to_lockout", data_gnt, 1'b0);
`else
      repeat (300) tick();
      chk("hold_forever_gnt", data_gnt, 1'b1);
      chk("hold_forever_led", led, 1'b1);
      chk("hold_no_timeout", timeout, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
